traffic_phase_ctrl: RTL



---
 rtl/traffic_phase_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Phase sequencer for a two-road intersection. Steps through main green,
// main yellow, all-red, side green, side yellow, all-red, with a countdown
// timer per phase. Main green is a resting phase: once its minimum time has
// run out it is held until a side-road vehicle or a latched pedestrian
// request asks for the side road.
//
// The phase code and a one-cycle load strobe feed a downstream 4-bit phase
// register (phase_code -> data, load -> enable).
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   enable      advance enable; low freezes timer/state and suppresses load
//   sensor      side-road vehicle present (level)
//   ped_req     pedestrian button (pulse or level), latched into ped_pend
//   phase_code  current phase code (1..6)
//   load        one-cycle strobe whenever a new phase must be captured
//   main_light  main-road light: 00 red, 01 yellow, 10 green
//   side_light  side-road light, same encoding
//   timer       remaining count in the current phase
//   ped_pend    pedestrian request latched, waiting for the side green
// -----------------------------------------------------------------------------
module traffic_phase_ctrl #(
    parameter int GREEN_T      = 8,
    parameter int SIDE_GREEN_T = 5,
    parameter int YELLOW_T     = 3,
    parameter int ALLRED_T     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sensor,
    input  logic       ped_req,
    output logic [3:0] phase_code,
    output logic       load,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic [3:0] timer,
    output logic       ped_pend
);

    typedef enum logic [3:0] {
        MG  = 4'h1,
        MY  = 4'h2,
        AR1 = 4'h3,
        SG  = 4'h4,
        SY  = 4'h5,
        AR2 = 4'h6
    } state_t;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    localparam logic [3:0] MG_LOAD  = 4'(GREEN_T - 1);
    localparam logic [3:0] SG_LOAD  = 4'(SIDE_GREEN_T - 1);
    localparam logic [3:0] YEL_LOAD = 4'(YELLOW_T - 1);
    localparam logic [3:0] AR_LOAD  = 4'(ALLRED_T - 1);

    // The state register is kept as a plain 4-bit vector rather than the enum
    // type so that an upset into an unused code (0, 7..F) is representable and
    // can be steered back to MG by the default branch below.
    logic [3:0] state;
    logic [3:0] state_next;
    logic [3:0] timer_next;
    logic       load_next;
    logic       ped_next;
    logic       init_pend;
    logic       init_next;
    logic [1:0] main_next;
    logic [1:0] side_next;

    assign phase_code = state;

    // Timer reload value (duration - 1) for the phase being entered.
    function automatic logic [3:0] reload_of(input logic [3:0] s);
        case (s)
            MG:      reload_of = MG_LOAD;
            MY:      reload_of = YEL_LOAD;
            AR1:     reload_of = AR_LOAD;
            SG:      reload_of = SG_LOAD;
            SY:      reload_of = YEL_LOAD;
            AR2:     reload_of = AR_LOAD;
            default: reload_of = MG_LOAD;
        endcase
    endfunction

    // Next-state logic. The pedestrian latch runs regardless of enable; the
    // timer, state and the post-reset load request only move on enabled
    // edges. An illegal code recovers to the full reset values in one edge
    // whether or not the controller is enabled.
    always_comb begin
        state_next = state;
        timer_next = timer;
        load_next  = 1'b0;
        init_next  = init_pend;
        ped_next   = ped_pend | ped_req;

        case (state)
            MG, MY, AR1, SG, SY, AR2: begin
                if (enable) begin
                    // First enabled edge after reset re-announces MG so the
                    // downstream register is guaranteed to hold a valid code.
                    if (init_pend) begin
                        load_next = 1'b1;
                        init_next = 1'b0;
                    end

                    if (timer != 4'd0) begin
                        timer_next = timer - 4'd1;
                    end else begin
                        case (state)
                            MG:      if (sensor | ped_pend) state_next = MY;
                            MY:      state_next = AR1;
                            AR1:     state_next = SG;
                            SG:      state_next = SY;
                            SY:      state_next = AR2;
                            AR2:     state_next = MG;
                            default: state_next = MG;
                        endcase

                        // MG held at zero leaves state_next == state, so the
                        // timer stays parked at 0 with no load.
                        if (state_next != state) begin
                            timer_next = reload_of(state_next);
                            load_next  = 1'b1;
                        end

                        // Entering side green serves the pedestrian, unless
                        // the button is still being pressed on that edge.
                        if (state == AR1 && !ped_req) begin
                            ped_next = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_next = MG;
                timer_next = MG_LOAD;
                load_next  = 1'b0;
                init_next  = 1'b1;
                ped_next   = 1'b0;
            end
        endcase
    end

    // Light decode from the next state, registered alongside the state so
    // the lights change in the same cycle as phase_code.
    always_comb begin
        main_next = GRN;
        side_next = RED;
        case (state_next)
            MG:      begin main_next = GRN; side_next = RED; end
            MY:      begin main_next = YEL; side_next = RED; end
            AR1:     begin main_next = RED; side_next = RED; end
            SG:      begin main_next = RED; side_next = GRN; end
            SY:      begin main_next = RED; side_next = YEL; end
            AR2:     begin main_next = RED; side_next = RED; end
            default: begin main_next = GRN; side_next = RED; end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= MG;
            timer      <= MG_LOAD;
            load       <= 1'b0;
            ped_pend   <= 1'b0;
            init_pend  <= 1'b1;
            main_light <= GRN;
            side_light <= RED;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            load       <= load_next;
            ped_pend   <= ped_next;
            init_pend  <= init_next;
            main_light <= main_next;
            side_light <= side_next;
        end
    end

endmodule
